// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants, lane types and depth-legality check for the NTT delay line.
// Revision: 1.0
`default_nettype none

package ntt_pkg;

  localparam int NTT_WIDTH     = 32;
  localparam int NTT_LANES     = 2;
  localparam int NTT_MAX_DEPTH = 16;
  localparam int NTT_RST_DEPTH = 2;

  typedef logic [NTT_WIDTH-1:0] coeff_t;
  typedef coeff_t [NTT_LANES-1:0] lane_vec_t;

  function automatic logic depth_legal(input int unsigned d, input int unsigned max_depth);
    return (d >= 1) && (d <= max_depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ntt_delay_ram.sv
// ntt_delay_ram: circular sample store with per-entry valid tags; only the tags are reset.
// Revision: 1.0
`default_nettype none

module ntt_delay_ram #(
  parameter int DATA_W  = 64,
  parameter int ENTRIES = 16,
  localparam int AW     = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_tag_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_tag_o
);

  logic [DATA_W-1:0]  mem_q [ENTRIES];
  logic [ENTRIES-1:0] tag_q;

  always_ff @(posedge clk) begin
    mem_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      tag_q <= '0;
    end else begin
      tag_q[wr_addr_i] <= wr_tag_i;
    end
  end

  // Asynchronous read sees the pre-edge contents, so D = ENTRIES reads the slot being overwritten.
  assign rd_data_o = mem_q[rd_addr_i];
  assign rd_tag_o  = tag_q[rd_addr_i];

endmodule

`default_nettype wire

// File: rtl/ntt_delay_line.sv
// ntt_delay_line: multi-lane delay line with runtime depth, flush, depth error and occupancy.
// Revision: 1.0
`default_nettype none

module ntt_delay_line
  import ntt_pkg::*;
#(
  parameter int WIDTH     = NTT_WIDTH,
  parameter int LANES     = NTT_LANES,
  parameter int MAX_DEPTH = NTT_MAX_DEPTH,
  parameter int RST_DEPTH = NTT_RST_DEPTH,
  localparam int DW       = $clog2(MAX_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_load,
  input  logic [DW-1:0]          cfg_depth,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [DW-1:0]          depth,
  output logic [DW-1:0]          occupancy,
  output logic                   depth_err
);

  localparam int AW     = $clog2(MAX_DEPTH);
  localparam int DATA_W = LANES * WIDTH;
  localparam logic [DW-1:0] RST_DEPTH_C = DW'(RST_DEPTH);

  logic [AW-1:0]     wp_q;
  logic [DW-1:0]     depth_q;
  logic [DW-1:0]     occ_q;
  logic [DW-1:0]     occ_d;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              depth_err_q;

  logic              load_ok;
  logic              clear;
  logic              accept;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_tag;

  always_comb begin
    load_ok = cfg_load & depth_legal(int'(cfg_depth), MAX_DEPTH);
    clear   = load_ok | flush;
    accept  = in_valid & ~clear;
    // Modulo-MAX_DEPTH subtraction: a depth of MAX_DEPTH lands on the write slot itself.
    rd_addr = wp_q - depth_q[AW-1:0];
    occ_d   = occ_q;
    if (accept && !rd_tag) begin
      occ_d = occ_q + 1'b1;
    end else if (!accept && rd_tag) begin
      occ_d = occ_q - 1'b1;
    end
  end

  ntt_delay_ram #(
    .DATA_W  (DATA_W),
    .ENTRIES (MAX_DEPTH)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (clear),
    .wr_addr_i (wp_q),
    .wr_data_i (in_data),
    .wr_tag_i  (accept),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data),
    .rd_tag_o  (rd_tag)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q        <= '0;
      depth_q     <= RST_DEPTH_C;
      occ_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      depth_err_q <= 1'b0;
    end else begin
      wp_q        <= wp_q + 1'b1;
      depth_err_q <= cfg_load & ~load_ok;
      if (load_ok) begin
        depth_q <= cfg_depth;
      end
      if (clear) begin
        occ_q       <= '0;
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
      end else begin
        occ_q       <= occ_d;
        out_valid_q <= rd_tag;
        out_data_q  <= rd_tag ? rd_data : '0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign depth     = depth_q;
  assign occupancy = occ_q;
  assign depth_err = depth_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ntt_delay_line.sv
// tb_ntt_delay_line: scoreboard bench; expected outputs are queued as stimulus is driven.
// Revision: 1.0
`default_nettype none

module tb_ntt_delay_line;
  import ntt_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_load = 1'b0;
  logic [4:0]  cfg_depth = '0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        out_valid;
  logic [63:0] out_data;
  logic [4:0]  depth;
  logic [4:0]  occupancy;
  logic        depth_err;

  typedef struct {
    int          acc;
    int          due;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  int   cnt = 0;
  int   checks = 0;
  int   failures = 0;
  int   exp_depth = 2;
  bit   mon_en = 1'b0;

  ntt_delay_line dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_load  (cfg_load),
    .cfg_depth (cfg_depth),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .depth     (depth),
    .occupancy (occupancy),
    .depth_err (depth_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  // Output monitor: pops the scoreboard entry due at this edge, else expects a bubble.
  always @(posedge clk) begin
    logic        ev;
    logic [63:0] ed;
    int          eo;
    #1;
    if (mon_en) begin
      ev = 1'b0;
      ed = '0;
      if (sb.size() > 0 && sb[0].due == cnt) begin
        ev = 1'b1;
        ed = sb[0].data;
        void'(sb.pop_front());
      end
      checks++;
      if (out_valid !== ev || out_data !== ed) begin
        failures++;
        $display("FAIL out_stream edge=%0d got v=%b d=%h expected v=%b d=%h", cnt, out_valid, out_data, ev, ed);
      end
      eo = 0;
      foreach (sb[i]) if (sb[i].acc <= cnt) eo++;
      checks++;
      if (int'(occupancy) !== eo) begin
        failures++;
        $display("FAIL occupancy edge=%0d got %0d expected %0d", cnt, occupancy, eo);
      end
    end
  end

  function automatic logic [63:0] mk(input int v);
    lane_vec_t r;
    r[0] = coeff_t'(v);
    r[1] = coeff_t'(v) ^ 32'hA5A5_0000;
    return r;
  endfunction

  task automatic drive(input bit v, input logic [63:0] d, input bit ld, input logic [4:0] cd, input bit fl);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    cfg_load  = ld;
    cfg_depth = cd;
    flush     = fl;
    if (ld && cd >= 5'd1 && cd <= 5'd16) begin
      sb.delete();
      exp_depth = int'(cd);
    end else if (fl) begin
      sb.delete();
    end else if (v) begin
      sb.push_back('{acc: cnt + 1, due: cnt + 1 + exp_depth, data: d});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 64'h0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 64'h0) begin
      failures++;
      $display("FAIL reset_out got v=%b d=%h expected v=0 d=0", out_valid, out_data);
    end
    checks++;
    if (depth !== 5'd2) begin
      failures++;
      $display("FAIL reset_depth got %0d expected 2", depth);
    end
    checks++;
    if (occupancy !== 5'd0 || depth_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_occ_err got occ=%0d err=%b expected 0 0", occupancy, depth_err);
    end
    rst_n     = 1'b1;
    exp_depth = 2;
    mon_en    = 1'b1;
  endtask

  task automatic test_basic;
    int peak = 0;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, mk(k), 1'b0, 5'd0, 1'b0);
      if (int'(occupancy) > peak) peak = int'(occupancy);
    end
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 64'h0, 1'b0, 5'd0, 1'b0);
      if (int'(occupancy) > peak) peak = int'(occupancy);
    end
    checks++;
    if (peak != 2) begin
      failures++;
      $display("FAIL basic_peak_occ got %0d expected 2", peak);
    end
  endtask

  task automatic test_depth5;
    drive(1'b0, 64'h0, 1'b1, 5'd5, 1'b0);
    drive(1'b1, mk(32'hA), 1'b0, 5'd0, 1'b0);
    drive(1'b0, mk(32'h77), 1'b0, 5'd0, 1'b0);
    drive(1'b1, mk(32'hB), 1'b0, 5'd0, 1'b0);
    checks++;
    if (depth !== 5'd5) begin
      failures++;
      $display("FAIL depth5_reg got %0d expected 5", depth);
    end
    idle(8);
  endtask

  task automatic test_illegal;
    logic [4:0] bad [2];
    bad[0] = 5'd0;
    bad[1] = 5'd17;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, mk(9), 1'b1, bad[i], 1'b0);
      drive(1'b0, 64'h0, 1'b0, 5'd0, 1'b0);
      checks++;
      if (depth_err !== 1'b1 || int'(depth) != exp_depth) begin
        failures++;
        $display("FAIL illegal_pulse cfg=%0d got err=%b depth=%0d expected err=1 depth=%0d", bad[i], depth_err, depth, exp_depth);
      end
      drive(1'b0, 64'h0, 1'b0, 5'd0, 1'b0);
      checks++;
      if (depth_err !== 1'b0) begin
        failures++;
        $display("FAIL illegal_one_cycle cfg=%0d got err=%b expected 0", bad[i], depth_err);
      end
      idle(6);
    end
  endtask

  task automatic test_flush;
    drive(1'b0, 64'h0, 1'b1, 5'd4, 1'b0);
    for (int k = 10; k <= 13; k++) drive(1'b1, mk(k), 1'b0, 5'd0, 1'b0);
    drive(1'b1, mk(14), 1'b0, 5'd0, 1'b1);
    for (int k = 15; k <= 19; k++) begin
      drive(1'b1, mk(k), 1'b0, 5'd0, 1'b0);
      if (k == 15) begin
        checks++;
        if (occupancy !== 5'd0 || out_valid !== 1'b0) begin
          failures++;
          $display("FAIL flush_clear got occ=%0d v=%b expected 0 0", occupancy, out_valid);
        end
      end
    end
    idle(6);
  endtask

  task automatic test_wrap;
    drive(1'b0, 64'h0, 1'b1, 5'd16, 1'b0);
    for (int k = 0; k < 40; k++) begin
      drive(1'b1, {8'(k), 24'hC0FFEE, 32'(k * 7 + 3)}, 1'b0, 5'd0, 1'b0);
      if (k == 30) begin
        checks++;
        if (occupancy !== 5'd16) begin
          failures++;
          $display("FAIL wrap_steady_occ got %0d expected 16", occupancy);
        end
      end
    end
    idle(18);
  endtask

  task automatic test_reset_mid;
    drive(1'b0, 64'h0, 1'b1, 5'd8, 1'b0);
    for (int k = 50; k < 55; k++) drive(1'b1, mk(k), 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = mk(55);
    sb.delete();
    exp_depth = 2;
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 64'h0 || depth !== 5'd2 || occupancy !== 5'd0) begin
      failures++;
      $display("FAIL reset_mid got v=%b d=%h depth=%0d occ=%0d expected 0 0 2 0", out_valid, out_data, depth, occupancy);
    end
    drive(1'b1, mk(77), 1'b0, 5'd0, 1'b0);
    idle(5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached at edge %0d", cnt);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_depth5();
    test_illegal();
    test_flush();
    test_wrap();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ntt_delay_line.md
Name: ntt_delay_line

Overview:
Multi-lane, runtime-programmable delay line for the NTT datapath. It aligns butterfly operands and commutator streams by delaying each accepted sample a configurable number of cycles, from 1 to MAX_DEPTH. Each sample carries a valid tag, so bubbles travel through the line and are reproduced exactly at the output. It sits between butterfly stages and generalises the fixed-depth buffer with these additions: lanes, runtime depth, flush, an error flag and an occupancy count.

Parameters:
WIDTH, 32, bits per lane (coefficient width)
LANES, 2, parallel coefficient lanes sharing one delay
MAX_DEPTH, 16, maximum delay in cycles; power of two, >= 2
RST_DEPTH, 2, delay after reset; 1..MAX_DEPTH
DW, $clog2(MAX_DEPTH)+1, width of depth and occupancy fields (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
cfg_load  in  1  load cfg_depth this cycle
cfg_depth  in  DW  requested delay D
flush  in  1  discard all in-flight samples
in_valid  in  1  sample present on in_data
in_data  in  LANES*WIDTH  lane 0 in bits [WIDTH-1:0]
out_valid  out  1  delayed sample present
out_data  out  LANES*WIDTH  delayed sample; all zeros when out_valid=0
depth  out  DW  currently active delay
occupancy  out  DW  number of valid samples in flight
depth_err  out  1  one-cycle pulse on an illegal cfg_load

Behaviour:
- Reset (rst_n=0 at an edge):
  - All valid tags cleared.
  - out_valid=0, out_data=0, depth=RST_DEPTH, occupancy=0, depth_err=0.
  - Storage data is not reset.
- Latency:
  - A sample accepted at edge t (in_valid=1, no cfg_load or flush) appears with out_valid=1 after edge t+D.
  - D is cycle-exact and independent of other traffic.
  - Input bubbles appear as output bubbles at the same relative position.
- Line behaviour:
  - The line advances every cycle. There is no backpressure and no stall.
  - Storage is circular, MAX_DEPTH entries of LANES*WIDTH data plus 1 tag.
  - The write pointer wraps modulo MAX_DEPTH.
  - The read pointer is derived from the write pointer and D, with wrap.
- cfg_load:
  - Legal when 1 <= cfg_depth <= MAX_DEPTH.
  - Legal load: depth <= cfg_depth at the edge, and all tags are cleared (implicit flush).
  - Legal load: out_valid=0 and occupancy=0 on the following cycle.
  - Illegal load (0 or > MAX_DEPTH): depth is unchanged, tags are untouched, depth_err=1 for exactly one cycle.
- flush: clears all tags; out_valid=0 and occupancy=0 on the next cycle.
- Same-cycle priority: rst_n > cfg_load (legal) > flush > in_valid.
  - A sample presented in the same cycle as a legal cfg_load or flush is dropped.
  - An illegal cfg_load does not drop the sample.
- occupancy per cycle:
  - +1 on an accepted input, -1 on out_valid.
  - Both or neither: unchanged.
  - Never exceeds D and never underflows.
- D = MAX_DEPTH: every storage entry is in use. Wrap-around must not corrupt data; this is the main boundary case.
- Reset mid-stream: all in-flight samples are lost. The output is silent for RST_DEPTH cycles after the first post-reset input.

Decomposition:
- Package ntt_pkg holds:
  - default WIDTH, LANES, MAX_DEPTH constants
  - typedef coeff_t (logic [WIDTH-1:0])
  - typedef lane_vec_t (array of LANES coeff_t)
  - the depth-legality check as a function
- Sub-module ntt_delay_ram holds storage and tags:
  - simple dual-port, one write and one read per cycle
  - synchronous reset of the tags only
- The top level owns the pointers, depth register, occupancy counter, flush and cfg logic.

Test Plan:
1. After reset (depth=2), stream lane values 1,2,3,4 on consecutive cycles from edge 0. Required: out_data 1,2,3,4 after edges 2..5 with out_valid=1, then out_valid=0 and out_data=0; occupancy peaks at 2.
2. cfg_load cfg_depth=5, then inputs A,bubble,B. Required: A at +5, bubble at +6 (out_valid=0), B at +7; depth reads 5.
3. cfg_load cfg_depth=0, and separately cfg_depth=17 (MAX_DEPTH=16), each with in_valid=1 value 9. Required: depth_err one-cycle pulse each time; depth unchanged; value 9 emerges D cycles later.
4. depth=4 stream 10..19; assert flush together with input 14. Required: 10..13 are lost if not yet out; 14 is dropped; 15..19 emerge 4 cycles after their input; occupancy=0 right after the flush.
5. depth=16, stream 40 consecutive samples 0..39. Required: sample k appears exactly 16 cycles after it was applied, with no corruption across pointer wrap; steady occupancy=16.
6. depth=8 mid-stream; drive rst_n=0 for one edge. Required: outputs zero, depth=2, occupancy=0; the next input emerges after 2 cycles.
